uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receive engine, the successor to the fixed 8N1 receiver. It deserialises an asynchronous `rx` line using the oversampling `s_tick` strobe from the shared baud-rate generator. Data width, stop length, oversampling ratio and optional parity are parameters. It adds input synchronisation, false-start rejection, parity/framing error reporting and a held output word, and feeds the UART interface/FIFO layer.

## Interface
- `DBIT`, 8, data bits per frame, legal 5..9
- `OVS`, 16, s_tick strobes per bit period, even, ≥ 4
- `SB_TICK`, 16, s_tick strobes spent in the stop bit: OVS for 1 stop bit, 3·OVS/2 for 1.5, 2·OVS for 2
- `PARITY_EN`, 0, 1 inserts a parity bit after the data bits
- `PARITY_ODD`, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0
- `clk` input 1 system clock; all logic on rising edge
- `reset` input 1 synchronous, active-high
- `s_tick` input 1 one-`clk` strobe at OVS × baud rate
- `rx` input 1 asynchronous serial line, idle high
- `dout` output DBIT last received word, held until the next frame completes
- `rx_done_tick` output 1 one-`clk` pulse when a frame completes
- `parity_err` output 1 parity mismatch on last frame, valid with and held after done
- `frame_err` output 1 stop bit sampled low on last frame, valid with and held after done
- `busy` output 1 high whenever state ≠ IDLE

## Operation
- `rx` passes through a two-flop synchroniser (reset value 1). All decisions use the synchronised `rx_s`.
- State, tick counter `s` (width clog2(SB_TICK)), bit counter `n` (width clog2(DBIT)) and shift register `b` change only on `clk` edges where `s_tick`=1. The exception is `rx_done_tick`, which deasserts on the next `clk` regardless of `s_tick`.
- IDLE: when `rx_s`=0, clear `s` and go to START.
- START: when `s`=OVS/2−1, sample mid-bit.
  - If `rx_s`=0, clear `s` and `n` and go to DATA.
  - If `rx_s`=1 (false start), return to IDLE with no done pulse and no flag change.
  - Otherwise increment `s`.
- DATA: when `s`=OVS−1, shift right with `b[DBIT−1]`←`rx_s` (LSB first) and clear `s`.
  - If `n`=DBIT−1, go to PARITY when PARITY_EN=1, else to STOP.
  - Otherwise increment `n`.
- PARITY: when `s`=OVS−1, latch `pbit`←`rx_s`, clear `s` and go to STOP.
- STOP: sample `rx_s` when `s`=OVS−1. When `s`=SB_TICK−1, the frame completes:
  - `dout`←`b`
  - `frame_err`←(sample==0)
  - `parity_err`←PARITY_EN & (^b ^ pbit ^ PARITY_ODD)
  - pulse `rx_done_tick`, go to IDLE
- Error flags are not sticky. Each completed frame overwrites them.
- `reset` has priority over everything, including mid-frame.
  - State goes to IDLE; counters, `b` and `pbit` clear.
  - `dout`=0, `rx_done_tick`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - Synchroniser flops are set to 1.

## Timing
- Input latency: two `clk` cycles from `rx` to `rx_s`.
- `rx_done_tick`, `dout` and the flags all update on the `clk` edge of the s_tick that ends STOP. The pulse lasts exactly one `clk`.
- Frame length from the start edge to done is OVS/2 + (DBIT + PARITY_EN)·OVS + SB_TICK s_ticks (±1 tick of detection jitter).
- A new start edge is accepted from the s_tick immediately after done, so back-to-back frames are supported.
- A break (line held low) produces one frame with `dout`=0 and `frame_err`=1, then restarts on the next low sample. This is the required behaviour.
- `s_tick` asserted on consecutive `clk` cycles is legal; each strobe counts once.

## Structure
- Shared package `uart_pkg`:
  - state encoding (one-hot, 5 states)
  - parity-mode constants
  - `clog2` helper, shared with the transmitter
- Sub-module `sync_2ff`: parametrised-reset two-flop synchroniser, reused for other async inputs.
- Everything else lives in `uart_rx_param`; no datapath sub-module.

## Test plan
- 8N1 defaults, `s_tick` every 4 `clk`, send 0xA5 → one `rx_done_tick`, `dout`=0xA5, both flags 0, `busy` low afterwards.
- PARITY_EN=1, even parity, send 0x37 with parity bit 0 (correct bit is 1) → `dout`=0x37, `parity_err`=1. Resend with bit 1 → `parity_err`=0.
- Send 0x3C with stop bit driven 0 → `dout`=0x3C, `frame_err`=1. Next valid frame 0x01 → `frame_err`=0.
- Drive `rx` low for 3 s_ticks, then high → no done pulse, state returns to IDLE, `dout` unchanged.
- Assert `reset` for one `clk` during data bit 4 of 0xFF → all outputs 0, IDLE. Following frame 0x5A received correctly.
- DBIT=7, SB_TICK=32, two frames 0x41 and 0x7F back-to-back → two done pulses with matching `dout`, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive/transmit engines.
//   rx_state_e : one-hot receiver state encoding (5 states)
//   PAR_EVEN / PAR_ODD : parity-mode constants for the PARITY_ODD parameter
//   clog2()    : ceiling log2 used to size counters at elaboration time
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      START  = 5'b00010,
      DATA   = 5'b00100,
      PARITY = 5'b01000,
      STOP   = 5'b10000
   } rx_state_e;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

   // Number of bits needed to count 0..value-1.
   function automatic int clog2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input. The reset value is a
// parameter so idle-high lines (e.g. UART rx) do not see a false edge when
// reset is released.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high; loads both flops with RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic sync_p0;
   logic sync_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= RESET_VAL;
         sync_p1 <= RESET_VAL;
      end else begin
         sync_p0 <= d;
         sync_p1 <= sync_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receive engine. Oversamples the rx line with the s_tick
// strobe, rejects false starts, reports parity and framing errors and holds
// the last received word until the next frame completes.
// Parameters:
//   DBIT       : data bits per frame (5..9)
//   OVS        : s_tick strobes per bit period (even, >= 4)
//   SB_TICK    : s_tick strobes spent in the stop bit(s)
//   PARITY_EN  : 1 expects a parity bit after the data bits
//   PARITY_ODD : 1 odd parity, 0 even parity
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high, highest priority
//   s_tick       : one-clk strobe at OVS x baud rate
//   rx           : asynchronous serial input, idle high
//   dout         : last received word (held)
//   rx_done_tick : one-clk pulse when a frame completes
//   parity_err   : parity mismatch on the last frame (held)
//   frame_err    : stop bit sampled low on the last frame (held)
//   busy         : receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int OVS        = 16,
   parameter int SB_TICK    = 16,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = PAR_EVEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            parity_err,
   output logic            frame_err,
   output logic            busy
);

   localparam int SW = clog2(SB_TICK);
   localparam int NW = clog2(DBIT);

   localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   logic            rx_s;

   rx_state_e       state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            pbit_q, pbit_d;
   logic            stop_q, stop_d;
   logic [DBIT-1:0] dout_d;
   logic            perr_d, ferr_d, done_d;
   logic            stop_smp;

   // rx idles high, so the synchroniser resets to 1 to avoid a phantom start.
   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // With a single stop bit the mid-bit sample and the end of STOP fall on
   // the same tick, so the live rx_s must be used instead of the latch.
   assign stop_smp = (s_q == S_BIT) ? rx_s : stop_q;

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      pbit_d  = pbit_q;
      stop_d  = stop_q;
      dout_d  = dout;
      perr_d  = parity_err;
      ferr_d  = frame_err;
      done_d  = 1'b0;

      if (s_tick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  s_d     = '0;
                  state_d = START;
               end
            end

            START: begin
               if (s_q == S_HALF) begin
                  if (!rx_s) begin
                     s_d     = '0;
                     n_d     = '0;
                     state_d = DATA;
                  end else begin
                     // Glitch shorter than half a bit: drop silently.
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end

            DATA: begin
               if (s_q == S_BIT) begin
                  s_d = '0;
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = PARITY_EN ? PARITY : STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end

            PARITY: begin
               if (s_q == S_BIT) begin
                  pbit_d  = rx_s;
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end

            STOP: begin
               if (s_q == S_BIT) begin
                  stop_d = rx_s;
               end
               if (s_q == S_STOP) begin
                  dout_d  = b_q;
                  ferr_d  = ~stop_smp;
                  perr_d  = PARITY_EN & ((^b_q) ^ pbit_q ^ PARITY_ODD);
                  done_d  = 1'b1;
                  s_d     = '0;
                  state_d = IDLE;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end

            default: begin
               state_d = IDLE;
               s_d     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         s_q          <= '0;
         n_q          <= '0;
         b_q          <= '0;
         pbit_q       <= 1'b0;
         stop_q       <= 1'b0;
         dout         <= '0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         b_q          <= b_d;
         pbit_q       <= pbit_d;
         stop_q       <= stop_d;
         dout         <= dout_d;
         parity_err   <= perr_d;
         frame_err    <= ferr_d;
         rx_done_tick <= done_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Directed bench for uart_rx_param. Three instances:
//   A : 8N1 defaults
//   B : 8 data bits, even parity
//   C : 7 data bits, two stop bits (SB_TICK = 32)
// s_tick fires every 4th clk; all stimulus and sampling happen on negedge.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic s_tick = 1'b0;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;
   logic rx_c = 1'b1;

   logic [7:0] dout_a;
   logic [7:0] dout_b;
   logic [6:0] dout_c;
   logic done_a, done_b, done_c;
   logic perr_a, perr_b, perr_c;
   logic ferr_a, ferr_b, ferr_c;
   logic busy_a, busy_b, busy_c;

   int checks = 0;
   int errors = 0;
   int cnt_a = 0;
   int cnt_b = 0;
   int cnt_c = 0;
   int tick_div = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tick_div == 3) begin
         tick_div <= 0;
         s_tick   <= 1'b1;
      end else begin
         tick_div <= tick_div + 1;
         s_tick   <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (done_a) cnt_a = cnt_a + 1;
      if (done_b) cnt_b = cnt_b + 1;
      if (done_c) cnt_c = cnt_c + 1;
   end

   uart_rx_param u_a (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_a),
      .dout(dout_a), .rx_done_tick(done_a), .parity_err(perr_a),
      .frame_err(ferr_a), .busy(busy_a)
   );

   uart_rx_param #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_b (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_b),
      .dout(dout_b), .rx_done_tick(done_b), .parity_err(perr_b),
      .frame_err(ferr_b), .busy(busy_b)
   );

   uart_rx_param #(.DBIT(7), .SB_TICK(32)) u_c (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_c),
      .dout(dout_c), .rx_done_tick(done_c), .parity_err(perr_c),
      .frame_err(ferr_c), .busy(busy_c)
   );

   task automatic set_rx(input int inst, input logic v);
      case (inst)
         0: rx_a = v;
         1: rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   function automatic int get_cnt(input int inst);
      case (inst)
         0: return cnt_a;
         1: return cnt_b;
         default: return cnt_c;
      endcase
   endfunction

   task automatic wait_ticks(input int k);
      int seen = 0;
      while (seen < k) begin
         @(negedge clk);
         if (s_tick) seen = seen + 1;
      end
   endtask

   // Bounded wait for the done counter of an instance to reach target.
   task automatic wait_done(input int inst, input int target);
      int cyc = 0;
      while (get_cnt(inst) < target && cyc < 400) begin
         @(negedge clk);
         cyc = cyc + 1;
      end
   endtask

   task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                             input bit par_en, input bit par_bit,
                             input bit stop_val, input int stop_ticks);
      set_rx(inst, 1'b0);
      wait_ticks(16);
      for (int i = 0; i < nbits; i++) begin
         set_rx(inst, data[i]);
         wait_ticks(16);
      end
      if (par_en) begin
         set_rx(inst, par_bit);
         wait_ticks(16);
      end
      set_rx(inst, stop_val);
      wait_ticks(stop_ticks);
      set_rx(inst, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({dout_a, done_a, perr_a, ferr_a, busy_a} !== 12'h000) begin
         errors++;
         $display("FAIL reset_a: got %h expected 000", {dout_a, done_a, perr_a, ferr_a, busy_a});
      end
      checks++;
      if ({dout_b, done_b, perr_b, ferr_b, busy_b} !== 12'h000) begin
         errors++;
         $display("FAIL reset_b: got %h expected 000", {dout_b, done_b, perr_b, ferr_b, busy_b});
      end
      checks++;
      if ({dout_c, done_c, perr_c, ferr_c, busy_c} !== 11'h000) begin
         errors++;
         $display("FAIL reset_c: got %h expected 000", {dout_c, done_c, perr_c, ferr_c, busy_c});
      end
      reset = 1'b0;
      wait_ticks(4);
   endtask

   task automatic test_basic_8n1();
      int base = cnt_a;
      send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 16);
      wait_done(0, base + 1);
      checks++;
      if (cnt_a !== base + 1) begin
         errors++;
         $display("FAIL 8n1_done_count: got %0d expected %0d", cnt_a - base, 1);
      end
      checks++;
      if (dout_a !== 8'hA5) begin
         errors++;
         $display("FAIL 8n1_dout: got %h expected a5", dout_a);
      end
      checks++;
      if ({perr_a, ferr_a} !== 2'b00) begin
         errors++;
         $display("FAIL 8n1_flags: got %b expected 00", {perr_a, ferr_a});
      end
      wait_ticks(32);
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL 8n1_busy_after: got %b expected 0", busy_a);
      end
   endtask

   task automatic test_frame_err();
      int base = cnt_a;
      send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 16);
      wait_done(0, base + 1);
      checks++;
      if (dout_a !== 8'h3C) begin
         errors++;
         $display("FAIL ferr_dout: got %h expected 3c", dout_a);
      end
      checks++;
      if ({perr_a, ferr_a} !== 2'b01) begin
         errors++;
         $display("FAIL ferr_flags: got %b expected 01", {perr_a, ferr_a});
      end
      wait_ticks(48);
      checks++;
      if (cnt_a !== base + 1) begin
         errors++;
         $display("FAIL ferr_no_extra_done: got %0d expected %0d", cnt_a - base, 1);
      end
      send_frame(0, 9'h001, 8, 1'b0, 1'b0, 1'b1, 16);
      wait_done(0, base + 2);
      checks++;
      if ({dout_a, ferr_a} !== {8'h01, 1'b0}) begin
         errors++;
         $display("FAIL ferr_clear: got %h/%b expected 01/0", dout_a, ferr_a);
      end
      wait_ticks(32);
   endtask

   task automatic test_false_start();
      int base = cnt_a;
      set_rx(0, 1'b0);
      wait_ticks(3);
      set_rx(0, 1'b1);
      wait_ticks(32);
      checks++;
      if (cnt_a !== base) begin
         errors++;
         $display("FAIL false_start_done: got %0d expected 0", cnt_a - base);
      end
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL false_start_idle: got %b expected 0", busy_a);
      end
      checks++;
      if (dout_a !== 8'h01) begin
         errors++;
         $display("FAIL false_start_dout: got %h expected 01", dout_a);
      end
   endtask

   task automatic test_parity();
      int base = cnt_b;
      // 0x37 has five ones: even parity bit must be 1.
      send_frame(1, 9'h037, 8, 1'b1, 1'b0, 1'b1, 16);
      wait_done(1, base + 1);
      checks++;
      if ({dout_b, perr_b, ferr_b} !== {8'h37, 2'b10}) begin
         errors++;
         $display("FAIL parity_bad: got %h/%b%b expected 37/10", dout_b, perr_b, ferr_b);
      end
      wait_ticks(32);
      send_frame(1, 9'h037, 8, 1'b1, 1'b1, 1'b1, 16);
      wait_done(1, base + 2);
      checks++;
      if ({dout_b, perr_b, ferr_b} !== {8'h37, 2'b00}) begin
         errors++;
         $display("FAIL parity_good: got %h/%b%b expected 37/00", dout_b, perr_b, ferr_b);
      end
      checks++;
      if (cnt_b !== base + 2) begin
         errors++;
         $display("FAIL parity_done_count: got %0d expected 2", cnt_b - base);
      end
      wait_ticks(32);
   endtask

   task automatic test_back_to_back();
      int base = cnt_c;
      send_frame(2, 9'h041, 7, 1'b0, 1'b0, 1'b1, 32);
      checks++;
      if ({cnt_c - base, dout_c} !== {32'd1, 7'h41}) begin
         errors++;
         $display("FAIL b2b_first: got %0d/%h expected 1/41", cnt_c - base, dout_c);
      end
      send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 1'b1, 32);
      wait_done(2, base + 2);
      checks++;
      if ({cnt_c - base, dout_c} !== {32'd2, 7'h7F}) begin
         errors++;
         $display("FAIL b2b_second: got %0d/%h expected 2/7f", cnt_c - base, dout_c);
      end
      checks++;
      if ({perr_c, ferr_c} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_flags: got %b expected 00", {perr_c, ferr_c});
      end
      wait_ticks(32);
   endtask

   task automatic test_reset_midframe();
      int base = cnt_a;
      set_rx(0, 1'b0);
      wait_ticks(16);
      set_rx(0, 1'b1);
      wait_ticks(64 + 8);
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("FAIL midframe_busy: got %b expected 1", busy_a);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({dout_a, done_a, perr_a, ferr_a, busy_a} !== 12'h000) begin
         errors++;
         $display("FAIL midframe_reset: got %h expected 000", {dout_a, done_a, perr_a, ferr_a, busy_a});
      end
      wait_ticks(8 + 48 + 16 + 32);
      checks++;
      if ({cnt_a - base, busy_a} !== {32'd0, 1'b0}) begin
         errors++;
         $display("FAIL midframe_aborted: got %0d/%b expected 0/0", cnt_a - base, busy_a);
      end
      send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 16);
      wait_done(0, base + 1);
      checks++;
      if ({cnt_a - base, dout_a, perr_a, ferr_a} !== {32'd1, 8'h5A, 2'b00}) begin
         errors++;
         $display("FAIL after_reset_frame: got %0d/%h/%b%b expected 1/5a/00",
                  cnt_a - base, dout_a, perr_a, ferr_a);
      end
   endtask

   initial begin
      test_reset();
      test_basic_8n1();
      test_frame_err();
      test_false_start();
      test_parity();
      test_back_to_back();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
